// File: rtl/ysyx_22051013_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22051013_ifu
// Brief    : RV64 instruction fetch unit. Fetch PC, valid/ready imem
//            requests, DEPTH-entry {pc, inst} FIFO toward decode, and
//            redirects from the branch predictor and EX.
// Revision : 1.0
// ============================================================================
module ysyx_22051013_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [63:0] id_pc,
  input  logic        id_ready,
  input  logic        bpu_jump,
  input  logic [63:0] bpu_pc,
  input  logic        ex_redirect,
  input  logic [63:0] ex_redirect_pc
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [63:0]   fetch_pc;
  logic [63:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [63:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];

  logic          req_fire;
  logic          id_fire;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          redirect;
  logic [63:0]   target;
  logic [CW:0]   occupancy;
  logic [CW-1:0] outstanding_nxt;

  // A request is only issued when a FIFO slot is reserved for its response.
  assign occupancy      = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = !rst && (occupancy < DEPTH_C);
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign id_fire  = id_valid && id_ready;
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0);
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);

  assign redirect = ex_redirect || (id_fire && bpu_jump);
  assign target   = ex_redirect ? ex_redirect_pc : bpu_pc;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  assign id_valid = (count != '0);
  assign id_inst  = fifo_inst[rd_ptr];
  assign id_pc    = fifo_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        // Everything still in flight after this edge belongs to the old
        // stream; responses already marked for dropping are among them.
        drop_cnt <= outstanding_nxt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 64'd4;
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + 64'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (id_fire) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(rsp_keep) - CW'(id_fire);
      end
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (!rst && !redirect && rsp_keep) begin
      fifo_pc[wr_ptr]   <= rsp_pc;
      fifo_inst[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051013_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22051013_ifu
// Brief    : Scoreboard bench for the fetch unit with a latency-randomised
//            instruction memory and a scripted branch predictor.
// Revision : 1.0
// ============================================================================
module tb_ysyx_22051013_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          DEPTH    = 4;
  localparam int          STREAM   = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
  logic        id_ready;
  logic        bpu_jump;
  logic [63:0] bpu_pc;
  logic        ex_redirect;
  logic [63:0] ex_redirect_pc;

  ysyx_22051013_ifu #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_ready(id_ready), .bpu_jump(bpu_jump), .bpu_pc(bpu_pc),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int delivered = 0;
  logic saw_jump = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected delivery stream: restarted whenever a redirect is issued.
  logic [63:0] exp_q[$];
  task automatic reload(input logic [63:0] start);
    exp_q.delete();
    for (int i = 0; i < STREAM; i++) exp_q.push_back(start + 64'(4 * i));
  endtask

  // Scripted predictor: 0 off, 1 single taken branch, 2 pattern rule, 3 forced.
  int          bpu_mode = 0;
  logic [63:0] force_tgt = '0;
  always_comb begin
    bpu_jump = 1'b0;
    bpu_pc   = '0;
    case (bpu_mode)
      1: begin
        bpu_jump = id_valid && (id_pc == 64'h0000_0000_8000_0008);
        bpu_pc   = 64'h0000_0000_8000_0100;
      end
      2: begin
        bpu_jump = id_valid && (id_pc[5:2] == 4'hA);
        bpu_pc   = id_pc + 64'h124;
      end
      3: begin
        bpu_jump = 1'b1;
        bpu_pc   = force_tgt;
      end
      default: ;
    endcase
  end

  // Instruction memory: in-order responses, latency lat_min..lat_max.
  typedef struct packed {
    logic [63:0] addr;
    int          due;
  } req_t;
  req_t pend[$];
  int lat_min = 1;
  int lat_max = 1;
  int ready_pct = 100;

  initial begin
    req_t r;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) pend.delete();
      else if (imem_req_valid && imem_req_ready) begin
        r.addr = imem_req_addr;
        r.due  = cyc + int'($urandom_range(lat_max, lat_min));
        pend.push_back(r);
      end
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (rst) pend.delete();
      else if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end
      imem_req_ready = (int'($urandom_range(99, 0)) < ready_pct);
    end
  end

  // Monitor: pops an expected entry for every instruction handed to decode.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("inflight_le_depth", 64'(pend.size() <= DEPTH), 64'd1);
        if (id_valid && id_ready && !ex_redirect) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got pc %h expected nothing", id_pc);
          end else begin
            e = exp_q.pop_front();
            check("id_pc", id_pc, e);
            check("id_inst", 64'(id_inst), 64'(mem_word(e)));
            delivered++;
            if (bpu_jump) begin
              saw_jump = 1'b1;
              reload(bpu_pc);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    reload(RESET_PC);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    id_ready = 1'b0;
    ex_redirect = 1'b0;
    ex_redirect_pc = '0;
    reload(RESET_PC);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    check("first_req_valid", 64'(imem_req_valid), 64'd1);
    check("first_req_addr", imem_req_addr, RESET_PC);
    repeat (30) @(posedge clk);

    // Decode stall: FIFO fills and fetch stops.
    #1;
    id_ready = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    #1;
    check("stall_req_valid", 64'(imem_req_valid), 64'd0);
    check("stall_id_valid", 64'(id_valid), 64'd1);
    check("stall_no_inflight", 64'(pend.size()), 64'd0);
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    repeat (20) @(posedge clk);

    // Predicted-taken branch at 0x8000_0008.
    lat_min = 2;
    lat_max = 2;
    bpu_mode = 1;
    do_reset(2);
    repeat (40) @(posedge clk);
    check("bpu_jump_taken", 64'(saw_jump), 64'd1);
    #1;
    bpu_mode = 0;

    // EX redirect coinciding with response, request and predictor redirect.
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (imem_rsp_valid && imem_req_valid && imem_req_ready && id_valid && id_ready) begin
        hit = 1'b1;
        force_tgt = 64'h0000_0000_8000_0700;
        bpu_mode = 3;
        ex_redirect = 1'b1;
        ex_redirect_pc = 64'h0000_0000_8000_0200;
        reload(64'h0000_0000_8000_0200);
      end
    end
    check("ex_sync_found", 64'(hit), 64'd1);
    @(posedge clk);
    #1;
    ex_redirect = 1'b0;
    bpu_mode = 0;
    @(negedge clk);
    #1;
    if (hit) begin
      check("ex_fifo_flushed", 64'(id_valid), 64'd0);
      check("ex_new_addr", imem_req_addr, 64'h0000_0000_8000_0200);
    end
    repeat (30) @(posedge clk);

    // Randomised traffic with redirects from both sources.
    lat_min = 1;
    lat_max = 5;
    ready_pct = 70;
    bpu_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      id_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(19, 0) == 0) begin
        ex_redirect = 1'b1;
        ex_redirect_pc = 64'h0000_0000_8000_0000 + {52'd0, 10'($urandom_range(1023, 0)), 2'b00};
        reload(ex_redirect_pc);
      end else begin
        ex_redirect = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    ex_redirect = 1'b0;
    bpu_mode = 0;
    id_ready = 1'b1;
    ready_pct = 100;
    lat_min = 3;
    lat_max = 3;

    // Reset with requests in flight.
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (pend.size() >= 2) begin
        hit = 1'b1;
        rst = 1'b1;
        reload(RESET_PC);
      end
    end
    check("midrst_inflight_found", 64'(hit), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("midrst_id_valid", 64'(id_valid), 64'd0);
    check("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_first_valid", 64'(imem_req_valid), 64'd1);
    check("midrst_first_addr", imem_req_addr, RESET_PC);
    repeat (30) @(posedge clk);

    check("delivered_enough", 64'(delivered > 200), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
